// File: rtl/pulsedet_pkg.sv
// Shared types and default parameter values for the pulse detector.
package pulsedet_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_QUAL_LEN   = 6;
  localparam int DEF_NOISE_COEF = 8;
  localparam int DEF_HOLD_W     = 12;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/sat_addsub.sv
// Saturating unsigned add/subtract: result computed in WIDTH+1 bits and
// clamped to [0, 2^WIDTH-1].
module sat_addsub #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] ext;

  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b};
    else     ext = {1'b0, a} + {1'b0, b};
    // Bit WIDTH is a carry on add and a borrow on subtract.
    if (!ext[WIDTH]) y = ext[WIDTH-1:0];
    else if (sub)    y = '0;
    else             y = '1;
  end

endmodule

// File: rtl/pulsedet_gen.sv
// Log-magnitude pulse detector: qualify/holdoff FSM, noise-riding floor and
// desensing threshold. Retriggering is built in when PULSEDET_GEN_RETRIG_EN is defined.
module pulsedet_gen
  import pulsedet_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int QUAL_LEN   = DEF_QUAL_LEN,
  parameter int NOISE_COEF = DEF_NOISE_COEF,
  parameter int HOLD_W     = DEF_HOLD_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ena,
  input  logic              det_ena,
  input  logic              noise_ride,
  input  logic              trigger_clr,
  input  logic [WIDTH-1:0]  mtl,
  input  logic [WIDTH-1:0]  desense_amt,
  input  logic [WIDTH-1:0]  desense_qual,
  input  logic [WIDTH-1:0]  retrig_diff,
  input  logic [HOLD_W-1:0] holdoff_len,
  input  logic [WIDTH-1:0]  logmag,
  output logic [WIDTH-1:0]  logmag_dly,
  output logic              trigger,
  output logic              slice_data,
  output logic [WIDTH-1:0]  thresh_out,
  output logic [WIDTH-1:0]  noise_out,
  output logic              retrigger_out,
  output logic              busy,
  output logic [CNT_W-1:0]  trig_count
);

  localparam int ACC_W = WIDTH + NOISE_COEF;

  state_t                     state, state_nxt;
  logic [HOLD_W-1:0]          hold_cnt, hold_nxt;
  logic [QUAL_LEN-1:0]        cross_pipe;
  logic [WIDTH-1:0]           lm_in;
  logic [QUAL_LEN:0][WIDTH-1:0] lm_pipe;
  logic [ACC_W-1:0]           acc, acc_nxt;
  logic [WIDTH-1:0]           floor_r, floor_sum, thresh, ds_thresh;
  logic [1:0]                 ds_pipe;
  logic [WIDTH:0]             qual_lvl;
  logic                       crossing, trigger_e, retrigger_e, ds_fire;

  assign crossing   = det_ena & (logmag > thresh);
  assign trigger_e  = (state == IDLE) & (&cross_pipe);
  assign noise_out  = acc[ACC_W-1:NOISE_COEF];
  assign thresh_out = thresh;
  assign logmag_dly = lm_pipe[QUAL_LEN];
  assign busy       = (state == HOLD);
  assign acc_nxt    = acc + {{NOISE_COEF{1'b0}}, logmag} - (acc >> NOISE_COEF);
  assign qual_lvl   = {1'b0, floor_r} + {1'b0, desense_qual};
  assign ds_fire    = (ds_pipe[1] | retrigger_e) & ({1'b0, logmag} > qual_lvl);

  sat_addsub #(.WIDTH(WIDTH)) u_floor_add (
    .a   (mtl),
    .b   (noise_out),
    .sub (1'b0),
    .y   (floor_sum)
  );

  sat_addsub #(.WIDTH(WIDTH)) u_desense_sub (
    .a   (logmag),
    .b   (desense_amt),
    .sub (1'b1),
    .y   (ds_thresh)
  );

`ifdef PULSEDET_GEN_RETRIG_EN
  logic [QUAL_LEN-1:0] rt_pipe;
  logic                rt_done;
  logic [WIDTH:0]      rt_lvl;
  logic                raw_retrig;

  assign rt_lvl      = {1'b0, thresh} + {1'b0, retrig_diff};
  assign raw_retrig  = (state == HOLD) & ({1'b0, logmag} > rt_lvl);
  // rt_done blocks repeat firing until the run of qualifying samples breaks.
  assign retrigger_e = (state == HOLD) & (&rt_pipe) & ~rt_done & ~trigger_clr;

  always_ff @(posedge clock) begin
    if (reset) begin
      rt_pipe       <= '0;
      rt_done       <= 1'b0;
      retrigger_out <= 1'b0;
    end else begin
      retrigger_out <= ena & retrigger_e;
      if (ena) begin
        rt_pipe <= {rt_pipe[QUAL_LEN-2:0], raw_retrig};
        rt_done <= &rt_pipe;
      end
    end
  end
`else
  assign retrigger_e   = 1'b0;
  assign retrigger_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (trigger_e) begin
          state_nxt = HOLD;
          hold_nxt  = holdoff_len;
        end
      end
      HOLD: begin
        // Exiting at a count of 1 makes holdoff_len samples of HOLD; 0 still gives one.
        if (trigger_clr)                   state_nxt = IDLE;
        else if (retrigger_e)              hold_nxt  = holdoff_len;
        else if (hold_cnt <= HOLD_W'(1))   state_nxt = IDLE;
        else                               hold_nxt  = hold_cnt - HOLD_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else if (ena) begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lm_in      <= '0;
      lm_pipe    <= '0;
      cross_pipe <= '0;
      slice_data <= 1'b0;
      acc        <= '0;
      floor_r    <= mtl;
      thresh     <= mtl;
      ds_pipe    <= '0;
      trigger    <= 1'b0;
      trig_count <= '0;
    end else begin
      lm_in   <= logmag;
      trigger <= ena & (trigger_e | retrigger_e);
      if (ena) begin
        lm_pipe    <= {lm_pipe[QUAL_LEN-1:0], lm_in};
        cross_pipe <= {cross_pipe[QUAL_LEN-2:0], crossing};
        slice_data <= cross_pipe[QUAL_LEN-1];
        ds_pipe    <= {ds_pipe[0], trigger_e};
        floor_r    <= noise_ride ? floor_sum : mtl;
        // Noise tracks only quiet IDLE samples so pulses do not inflate the floor.
        if (state == IDLE && !cross_pipe[0]) acc <= acc_nxt;
        if (ds_fire)                                 thresh <= ds_thresh;
        else if (state == IDLE || ds_pipe != 2'b00) thresh <= floor_r;
        if ((trigger_e | retrigger_e) && trig_count != '1)
          trig_count <= trig_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulsedet_gen.sv
// Directed self-checking bench for pulsedet_gen; expectations follow the
// build's PULSEDET_GEN_RETRIG_EN setting.
module tb_pulsedet_gen;

  logic        clock = 1'b0;
  logic        reset, ena, det_ena, noise_ride, trigger_clr;
  logic [9:0]  mtl, desense_amt, desense_qual, retrig_diff, logmag;
  logic [11:0] holdoff_len;
  logic [9:0]  logmag_dly, thresh_out, noise_out;
  logic        trigger, slice_data, retrigger_out, busy;
  logic [15:0] trig_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pulsedet_gen dut (
    .clock         (clock),
    .reset         (reset),
    .ena           (ena),
    .det_ena       (det_ena),
    .noise_ride    (noise_ride),
    .trigger_clr   (trigger_clr),
    .mtl           (mtl),
    .desense_amt   (desense_amt),
    .desense_qual  (desense_qual),
    .retrig_diff   (retrig_diff),
    .holdoff_len   (holdoff_len),
    .logmag        (logmag),
    .logmag_dly    (logmag_dly),
    .trigger       (trigger),
    .slice_data    (slice_data),
    .thresh_out    (thresh_out),
    .noise_out     (noise_out),
    .retrigger_out (retrigger_out),
    .busy          (busy),
    .trig_count    (trig_count)
  );

  // One sample: drive, clock, then settle so outputs are sampled mid-cycle.
  task automatic drive(input logic [9:0] v);
    logmag = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ena = 1'b1; det_ena = 1'b1; noise_ride = 1'b0; trigger_clr = 1'b0;
    mtl = 10'd100; desense_amt = 10'd60; desense_qual = 10'd63; retrig_diff = 10'd96;
    holdoff_len = 12'd100; logmag = 10'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (logmag_dly !== 10'd0) begin failures++; $display("FAIL rst_logmag_dly got=%0d exp=0", logmag_dly); end
    checks++; if (trigger !== 1'b0) begin failures++; $display("FAIL rst_trigger got=%0d exp=0", trigger); end
    checks++; if (slice_data !== 1'b0) begin failures++; $display("FAIL rst_slice got=%0d exp=0", slice_data); end
    checks++; if (thresh_out !== 10'd100) begin failures++; $display("FAIL rst_thresh got=%0d exp=100", thresh_out); end
    checks++; if (noise_out !== 10'd0) begin failures++; $display("FAIL rst_noise got=%0d exp=0", noise_out); end
    checks++; if (retrigger_out !== 1'b0) begin failures++; $display("FAIL rst_retrig got=%0d exp=0", retrigger_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if (trig_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", trig_count); end
  endtask

  task automatic test_noise();
    int trig_seen = 0;
    do_reset();
    for (int k = 0; k < 4096; k++) begin
      drive(10'd50);
      if (trigger) trig_seen++;
    end
    checks++; if (trig_seen != 0) begin failures++; $display("FAIL noise_no_trig got=%0d exp=0", trig_seen); end
    checks++; if (noise_out < 10'd46 || noise_out > 10'd50) begin failures++; $display("FAIL noise_level got=%0d exp=46..50", noise_out); end
    checks++; if (trig_count !== 16'd0) begin failures++; $display("FAIL noise_count got=%0d exp=0", trig_count); end
    checks++; if (thresh_out !== 10'd100) begin failures++; $display("FAIL noise_thresh_mtl got=%0d exp=100", thresh_out); end
    noise_ride = 1'b1;
    repeat (3) drive(10'd50);
    checks++; if (thresh_out < 10'd146 || thresh_out > 10'd150) begin failures++; $display("FAIL noise_ride_floor got=%0d exp=146..150", thresh_out); end
    mtl = 10'd1000;
    repeat (3) drive(10'd50);
    checks++; if (thresh_out !== 10'd1023) begin failures++; $display("FAIL noise_ride_sat got=%0d exp=1023", thresh_out); end
    mtl = 10'd100;
    noise_ride = 1'b0;
  endtask

  task automatic test_qualify();
    int trig_seen = 0;
    int first_c = -1;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      drive(k < 5 ? 10'd101 : 10'd0);
      if (trigger) trig_seen++;
    end
    checks++; if (trig_seen != 0) begin failures++; $display("FAIL qual_short got=%0d exp=0", trig_seen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL qual_short_busy got=%0d exp=0", busy); end
    for (int k = 0; k < 15; k++) begin
      drive(k < 6 ? 10'd101 : 10'd0);
      if (trigger && first_c < 0) first_c = k + 1;
      if (trigger) trig_seen++;
      if (k + 1 == 7) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL qual_busy got=%0d exp=1", busy); end
      end
    end
    checks++; if (first_c != 7) begin failures++; $display("FAIL qual_latency got=%0d exp=7", first_c); end
    checks++; if (trig_seen != 1) begin failures++; $display("FAIL qual_pulses got=%0d exp=1", trig_seen); end
    checks++; if (trig_count !== 16'd1) begin failures++; $display("FAIL qual_count got=%0d exp=1", trig_count); end
  endtask

  task automatic test_holdoff_zero();
    do_reset();
    holdoff_len = 12'd0;
    for (int k = 0; k < 10; k++) begin
      drive(k < 6 ? 10'd101 : 10'd0);
      if (k + 1 == 7) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hz_busy_in got=%0d exp=1", busy); end
      end
      if (k + 1 == 8) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hz_busy_out got=%0d exp=0", busy); end
      end
    end
    holdoff_len = 12'd100;
  endtask

  task automatic test_desense_holdoff();
    int trig_seen = 0;
    do_reset();
    for (int k = 0; k < 112; k++) begin
      drive(k < 9 ? 10'd400 : 10'd0);
      if (trigger) trig_seen++;
      case (k + 1)
        6: begin
          checks++; if (slice_data !== 1'b0) begin failures++; $display("FAIL dh_slice_c6 got=%0d exp=0", slice_data); end
        end
        7: begin
          checks++; if (trigger !== 1'b1) begin failures++; $display("FAIL dh_trig_c7 got=%0d exp=1", trigger); end
          checks++; if (slice_data !== 1'b1) begin failures++; $display("FAIL dh_slice_c7 got=%0d exp=1", slice_data); end
          checks++; if (logmag_dly !== 10'd0) begin failures++; $display("FAIL dh_dly_c7 got=%0d exp=0", logmag_dly); end
        end
        8: begin
          checks++; if (thresh_out !== 10'd100) begin failures++; $display("FAIL dh_thresh_c8 got=%0d exp=100", thresh_out); end
          checks++; if (logmag_dly !== 10'd400) begin failures++; $display("FAIL dh_dly_c8 got=%0d exp=400", logmag_dly); end
        end
        9: begin
          checks++; if (thresh_out !== 10'd340) begin failures++; $display("FAIL dh_desense got=%0d exp=340", thresh_out); end
        end
        15: begin
          checks++; if (slice_data !== 1'b1) begin failures++; $display("FAIL dh_slice_c15 got=%0d exp=1", slice_data); end
        end
        16: begin
          checks++; if (slice_data !== 1'b0) begin failures++; $display("FAIL dh_slice_c16 got=%0d exp=0", slice_data); end
          checks++; if (logmag_dly !== 10'd400) begin failures++; $display("FAIL dh_dly_c16 got=%0d exp=400", logmag_dly); end
        end
        17: begin
          checks++; if (logmag_dly !== 10'd0) begin failures++; $display("FAIL dh_dly_c17 got=%0d exp=0", logmag_dly); end
        end
        106: begin
          checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dh_busy_c106 got=%0d exp=1", busy); end
        end
        107: begin
          checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dh_busy_c107 got=%0d exp=0", busy); end
        end
        108: begin
          checks++; if (thresh_out !== 10'd100) begin failures++; $display("FAIL dh_thresh_idle got=%0d exp=100", thresh_out); end
        end
        default: ;
      endcase
    end
    checks++; if (trig_seen != 1) begin failures++; $display("FAIL dh_pulses got=%0d exp=1", trig_seen); end
  endtask

  task automatic test_retrigger();
    logic        exp_rt;
    logic [9:0]  exp_th;
    logic [15:0] exp_cnt;
    int          end_c;
`ifdef PULSEDET_GEN_RETRIG_EN
    exp_rt = 1'b1; exp_th = 10'd440; exp_cnt = 16'd2; end_c = 127;
`else
    exp_rt = 1'b0; exp_th = 10'd340; exp_cnt = 16'd1; end_c = 107;
`endif
    do_reset();
    for (int k = 0; k < 130; k++) begin
      drive((k < 9) ? 10'd400 : ((k >= 20 && k < 27) ? 10'd500 : 10'd0));
      if (k + 1 == 27) begin
        checks++; if (trigger !== exp_rt) begin failures++; $display("FAIL rt_trigger got=%0d exp=%0d", trigger, exp_rt); end
        checks++; if (retrigger_out !== exp_rt) begin failures++; $display("FAIL rt_pulse got=%0d exp=%0d", retrigger_out, exp_rt); end
        checks++; if (thresh_out !== exp_th) begin failures++; $display("FAIL rt_thresh got=%0d exp=%0d", thresh_out, exp_th); end
        checks++; if (trig_count !== exp_cnt) begin failures++; $display("FAIL rt_count got=%0d exp=%0d", trig_count, exp_cnt); end
      end
      if (k + 1 == 28) begin
        checks++; if (retrigger_out !== 1'b0) begin failures++; $display("FAIL rt_one_wide got=%0d exp=0", retrigger_out); end
      end
      if (k + 1 == end_c - 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rt_busy_last got=%0d exp=1", busy); end
      end
      if (k + 1 == end_c) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rt_busy_end got=%0d exp=0", busy); end
      end
    end
  endtask

  task automatic test_clr_vs_retrig();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      trigger_clr = (k == 26);
      drive((k < 9) ? 10'd400 : ((k >= 20 && k < 27) ? 10'd500 : 10'd0));
      if (k + 1 == 27) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cr_busy got=%0d exp=0", busy); end
        checks++; if (retrigger_out !== 1'b0) begin failures++; $display("FAIL cr_retrig got=%0d exp=0", retrigger_out); end
        checks++; if (trig_count !== 16'd1) begin failures++; $display("FAIL cr_count got=%0d exp=1", trig_count); end
      end
    end
    trigger_clr = 1'b0;
  endtask

  task automatic test_desense_sat_clr();
    do_reset();
    desense_amt = 10'd1000;
    for (int k = 0; k < 25; k++) begin
      trigger_clr = (k == 19);
      drive(k < 9 ? 10'd400 : 10'd0);
      if (k + 1 == 9) begin
        checks++; if (thresh_out !== 10'd0) begin failures++; $display("FAIL ds_sat got=%0d exp=0", thresh_out); end
      end
      if (k + 1 == 19) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy_before got=%0d exp=1", busy); end
      end
      if (k + 1 == 20) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy_after got=%0d exp=0", busy); end
      end
      if (k + 1 == 21) begin
        checks++; if (thresh_out !== 10'd100) begin failures++; $display("FAIL clr_thresh got=%0d exp=100", thresh_out); end
      end
    end
    trigger_clr = 1'b0;
    desense_amt = 10'd60;
  endtask

  task automatic test_reset_mid_hold();
    int late_trig = 0;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      reset = (k == 30);
      drive(k < 9 ? 10'd400 : 10'd0);
      if (k + 1 == 30) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_before got=%0d exp=1", busy); end
      end
      if (k + 1 == 31) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy_after got=%0d exp=0", busy); end
        checks++; if (trig_count !== 16'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", trig_count); end
        checks++; if (thresh_out !== 10'd100) begin failures++; $display("FAIL rm_thresh got=%0d exp=100", thresh_out); end
      end
      if (k + 1 >= 31 && trigger) late_trig++;
    end
    reset = 1'b0;
    checks++; if (late_trig != 0) begin failures++; $display("FAIL rm_no_trigger got=%0d exp=0", late_trig); end
  endtask

  task automatic test_det_ena();
    int trig_seen = 0;
    int slice_seen = 0;
    do_reset();
    det_ena = 1'b0;
    for (int k = 0; k < 14; k++) begin
      drive(10'd400);
      if (trigger) trig_seen++;
      if (slice_data) slice_seen++;
    end
    det_ena = 1'b1;
    checks++; if (trig_seen != 0) begin failures++; $display("FAIL de_no_trig got=%0d exp=0", trig_seen); end
    checks++; if (slice_seen != 0) begin failures++; $display("FAIL de_no_slice got=%0d exp=0", slice_seen); end
  endtask

  initial begin
    test_reset();
    test_noise();
    test_qualify();
    test_holdoff_zero();
    test_desense_holdoff();
    test_retrigger();
    test_clr_vs_retrig();
    test_desense_sat_clr();
    test_reset_mid_hold();
    test_det_ena();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulsedet_gen.md
PULSEDET_GEN -- requirements
Module: pulsedet_gen

Interface
REQ-001 Parameter WIDTH, default 10, width of log-magnitude samples, thresholds and the noise estimate.
REQ-002 Parameter QUAL_LEN, default 6, consecutive enabled samples above threshold needed to qualify a pulse (min 2).
REQ-003 Parameter NOISE_COEF, default 8, power-of-2 shift of the noise IIR.
REQ-004 Parameter HOLD_W, default 12, width of the holdoff counter.
REQ-005 Parameter CNT_W, default 16, width of the trigger counter.
REQ-006 Ports, in order:
 clock  in  1  system clock, single clock domain
 reset  in  1  synchronous, active-high
 ena  in  1  sample enable
 det_ena  in  1  detection enable; 0 forces no crossings
 noise_ride  in  1  1: threshold floor = mtl + noise estimate (saturated); 0: mtl
 trigger_clr  in  1  forces HOLD->IDLE
 mtl  in  WIDTH  minimum trigger level
 desense_amt  in  WIDTH  threshold offset below the pulse peak
 desense_qual  in  WIDTH  margin above floor required before desensing
 retrig_diff  in  WIDTH  margin above threshold required to retrigger
 holdoff_len  in  HOLD_W  HOLD duration in enabled samples
 logmag  in  WIDTH  unsigned log-magnitude input
 logmag_dly  out  WIDTH  logmag aligned to slice_data
 trigger  out  1  one-cycle qualified trigger pulse
 slice_data  out  1  sliced binary data
 thresh_out  out  WIDTH  current threshold
 noise_out  out  WIDTH  noise floor estimate
 retrigger_out  out  1  retrigger event
 busy  out  1  high in HOLD
 trig_count  out  CNT_W  triggers since reset, saturating

Function
REQ-007 State machine: IDLE, HOLD; reset enters IDLE; state and all pipelines advance only when ena=1, except the lm_dly input stage.
REQ-008 IDLE->HOLD on trigger_e = all QUAL_LEN bits of the crossing pipe set while in IDLE; crossing = det_ena & (logmag > thresh).
REQ-009 HOLD->IDLE when trigger_clr=1 or the holdoff counter reaches 0; trigger_clr wins over a same-cycle retrigger.
REQ-010 Holdoff counter loads holdoff_len on IDLE->HOLD and on each retrigger, and decrements once per enabled sample in HOLD; holdoff_len=0 gives HOLD lasting exactly one enabled sample.
REQ-011 trigger is registered (trigger_e | retrigger_e), one cycle wide, asserted QUAL_LEN+1 enabled samples after the first crossing sample.
REQ-012 slice_data is the oldest crossing-pipe bit, registered; logmag_dly is delayed QUAL_LEN+2 samples.
REQ-013 Noise IIR (WIDTH+NOISE_COEF bits): acc <= acc + logmag - (acc>>NOISE_COEF); updates only in IDLE with pipe[0]=0.
REQ-014 Floor = noise_ride ? min(mtl+noise, 2^WIDTH-1) : mtl, computed in WIDTH+1 bits and registered.
REQ-015 Desense fires two enabled samples after trigger_e (or on retrigger_e) if logmag > floor+desense_qual; it sets thresh = max(logmag-desense_amt, 0).
REQ-016 If desense does not fire, thresh <= floor in IDLE and during the two samples after trigger_e; otherwise thresh holds.
REQ-017 raw_retrig = HOLD & (logmag > thresh+retrig_diff), with the sum computed in WIDTH+1 bits (no wrap); retrigger_e = all QUAL_LEN retrig-pipe bits set and not already retriggered; it re-arms once the pipe is not all ones.
REQ-018 trig_count increments on each trigger pulse and saturates at 2^CNT_W-1.

Reset
REQ-019 Reset state: IDLE, all pipes 0, noise accumulator 0, thresh = mtl, counters 0, every output 0 except thresh_out = mtl.
REQ-020 Reset asserted in HOLD aborts in the same cycle; no trigger is emitted.

Configuration
REQ-021 Macro PULSEDET_GEN_RETRIG_EN: when defined, retriggering per REQ-017 is built in.
REQ-022 Without PULSEDET_GEN_RETRIG_EN, the retrigger logic is omitted, retrigger_out is tied to 0, and HOLD ends only per REQ-009.

Structure
REQ-023 Package pulsedet_pkg holds the state enum (IDLE, HOLD) and default parameter constants.
REQ-024 The saturating WIDTH+1->WIDTH adder/subtractor is sub-module sat_addsub; the rest is flat.

Verification
(All with WIDTH=10, QUAL_LEN=6, mtl=100, noise_ride=0, desense_amt=60, desense_qual=63, retrig_diff=96, holdoff_len=100, ena=1, det_ena=1.)
REQ-025 logmag=50 for 4096 samples -> no trigger; noise_out within 46..50; trig_count=0.
REQ-026 logmag=101 for 5 samples -> no trigger; for 6 samples -> one trigger pulse 7 samples after the first; busy=1.
REQ-027 Pulse of 400 -> thresh_out=340 two samples after trigger_e; HOLD for 100 samples, then busy=0 and thresh_out=100.
REQ-028 In HOLD with thresh=340, logmag=500 for 6 samples -> trigger and retrigger_out pulse, thresh_out=440, holdoff reloaded, trig_count=2; with the macro undefined -> no retrigger, trig_count=1.
REQ-029 desense_amt=1000 and a pulse of 400 -> thresh_out=0 (saturated); trigger_clr or reset mid-HOLD -> IDLE next cycle, busy=0.
